// File: rtl/seq_detect_pkg.sv
// Shared types and reset defaults for the programmable serial sequence detector.
package seq_detect_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  localparam logic [7:0] DEF_PAT = 8'hAB;
  localparam int         DEF_LEN = 8;

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter: one-cycle update on inc, synchronous clear wins over inc.
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_seq_detect.sv
// Programmable serial pattern detector; MATCH is Mealy (same cycle as the last bit), count/err registered.
// Define SEQ_DETECT_CFG_CHECK_EN to also reject loads with CFG_PAT bits set at or above CFG_LEN.
module prog_seq_detect
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         D_IN,
  input  logic                         CFG_LD,
  input  logic [PAT_W-1:0]             CFG_PAT,
  input  logic [$clog2(PAT_W+1)-1:0]   CFG_LEN,
  input  logic                         CFG_OVL,
  output logic                         MATCH,
  output logic [CNT_W-1:0]             MATCH_CNT,
  output logic                         CFG_ERR
);

  localparam int               LEN_W   = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  seq_state_t       state;
  // Only LEN-1 past bits are ever compared, so the oldest history bit is not stored.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_nxt;
  logic             ovl;
  logic             win_hit;
  logic             ld_ok;
  logic             ld_accept;

  assign window   = {hist, D_IN};
  assign len_mask = ~({PAT_W{1'b1}} << len);
  assign len_m1   = len - LEN_ONE;
  assign win_hit  = ((window ^ pat) & len_mask) == '0;
  assign MATCH    = EN && !CFG_LD && (state == ST_RUN) && win_hit;

`ifdef SEQ_DETECT_CFG_CHECK_EN
  logic [PAT_W-1:0] cfg_mask;
  assign cfg_mask = ~({PAT_W{1'b1}} << CFG_LEN);
  assign ld_ok    = (CFG_LEN != '0) && (CFG_LEN <= LEN_MAX) && ((CFG_PAT & ~cfg_mask) == '0);
`else
  assign ld_ok    = (CFG_LEN != '0) && (CFG_LEN <= LEN_MAX);
`endif

  assign ld_accept = CFG_LD && ld_ok;

  // Non-overlap mode restarts the fill on the match edge so the next hit needs LEN fresh bits.
  always_comb begin
    fill_nxt = fill;
    if (MATCH && !ovl) begin
      fill_nxt = '0;
    end else if (fill < len_m1) begin
      fill_nxt = fill + LEN_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist    <= '0;
      fill    <= '0;
      state   <= ST_FILL;
      pat     <= PAT_W'(DEF_PAT);
      len     <= LEN_W'(DEF_LEN);
      ovl     <= 1'b1;
      CFG_ERR <= 1'b0;
    end else begin
      CFG_ERR <= CFG_LD && !ld_ok;
      if (CFG_LD) begin
        if (ld_ok) begin
          pat   <= CFG_PAT;
          len   <= CFG_LEN;
          ovl   <= CFG_OVL;
          hist  <= '0;
          fill  <= '0;
          state <= (CFG_LEN == LEN_ONE) ? ST_RUN : ST_FILL;
        end
      end else if (EN) begin
        hist  <= window[PAT_W-2:0];
        fill  <= fill_nxt;
        state <= (fill_nxt >= len_m1) ? ST_RUN : ST_FILL;
      end
    end
  end

  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (MATCH),
    .clr (ld_accept),
    .cnt (MATCH_CNT)
  );

endmodule

// File: tb/tb_prog_seq_detect.sv
// Scoreboard bench for prog_seq_detect: directed scenarios plus randomized traffic vs a bit-queue model.
module tb_prog_seq_detect;

  localparam int PAT_W = 16;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              d_in = 1'b0;
  logic              cfg_ld = 1'b0;
  logic [PAT_W-1:0]  cfg_pat = '0;
  logic [4:0]        cfg_len = '0;
  logic              cfg_ovl = 1'b0;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;
  logic              cfg_err;

  prog_seq_detect #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .D_IN      (d_in),
    .CFG_LD    (cfg_ld),
    .CFG_PAT   (cfg_pat),
    .CFG_LEN   (cfg_len),
    .CFG_OVL   (cfg_ovl),
    .MATCH     (match),
    .MATCH_CNT (match_cnt),
    .CFG_ERR   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit m;
    int cnt;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: bits received since the last restart, plus the active configuration.
  bit          mq[$];
  logic [15:0] mpat;
  int          mlen;
  bit          movl;
  int          mcnt;
  bit          merr;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    mq.delete();
    mpat = 16'h00AB;
    mlen = 8;
    movl = 1'b1;
    mcnt = 0;
    merr = 1'b0;
  endfunction

  function automatic bit model_hit(input bit d);
    int base;
    if (mq.size() < mlen - 1) return 1'b0;
    base = mq.size() - (mlen - 1);
    for (int k = 0; k < mlen - 1; k++)
      if (mq[base + k] != mpat[mlen - 1 - k]) return 1'b0;
    return d == mpat[0];
  endfunction

  function automatic bit model_ld_ok(input logic [15:0] p, input int l);
    if (l < 1 || l > PAT_W) return 1'b0;
`ifdef SEQ_DETECT_CFG_CHECK_EN
    for (int i = l; i < PAT_W; i++)
      if (p[i]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit e, input bit d, input bit ld,
                      input logic [15:0] p, input int l, input bit o);
    exp_t x;
    bit   m;
    @(posedge clk);
    #1;
    rst = r; en = e; d_in = d; cfg_ld = ld; cfg_pat = p; cfg_len = 5'(l); cfg_ovl = o;
    if (r) begin
      model_reset();
      x.m = 1'b0; x.cnt = 0; x.err = 1'b0;
      exp_q.push_back(x);
      return;
    end
    m = e && !ld && model_hit(d);
    x.m = m; x.cnt = mcnt; x.err = merr;
    exp_q.push_back(x);
    if (ld) begin
      if (model_ld_ok(p, l)) begin
        mpat = p; mlen = l; movl = o; mq.delete(); mcnt = 0; merr = 1'b0;
      end else begin
        merr = 1'b1;
      end
    end else begin
      merr = 1'b0;
      if (e) begin
        if (m && mcnt < CMAX) mcnt++;
        if (m && !movl) mq.delete();
        else begin
          mq.push_back(d);
          if (mq.size() > PAT_W) void'(mq.pop_front());
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, '0, 0, 1'b0);
  endtask

  task automatic load(input logic [15:0] p, input int l, input bit o);
    step(1'b0, 1'b0, 1'b0, 1'b1, p, l, o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, bit'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("match", int'(match), int'(e.m));
      chk("match_cnt", int'(match_cnt), e.cnt);
      chk("cfg_err", int'(cfg_err), int'(e.err));
    end
  end

  initial begin
    int          r;
    int          l;
    logic [15:0] p;
    model_reset();

    do_reset();
    send(32'hAB, 8);                   // default pattern, single hit on 8th bit
    idle(2);

    do_reset();
    send(32'hA, 4);                    // EN gap in the middle of the pattern
    idle(3);
    send(32'hB, 4);
    idle(1);

    load(16'h0000, 0, 1'b1);           // rejected lengths keep the old pattern
    idle(1);
    load(16'h0005, PAT_W + 1, 1'b1);
    idle(1);
    send(32'hAB, 8);

    load(16'h0005, 3, 1'b1);           // 101 overlapping then non-overlapping
    send(32'h15, 5);
    load(16'h0005, 3, 1'b0);
    send(32'h15, 5);

    load(16'h0005, 3, 1'b1);           // saturation at CNT_W=2
    send(32'h2AA, 10);
    send(32'h5, 3);
    idle(1);

    do_reset();
    send(32'h15, 5);                   // reset mid-pattern discards partial hit
    do_reset();
    send(32'h0B, 3);
    send(32'hAB, 8);

    load(16'h0010, 4, 1'b1);           // high pattern bit beyond LEN
    idle(1);
    send(32'h0, 4);
    send(32'hAB, 8);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
      end else if (r < 5) begin
        l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PAT_W + 1) : $urandom_range(1, 5);
        p = 16'($urandom);
        if ($urandom_range(0, 1) == 1 && l <= PAT_W) p = p & ~(16'hFFFF << l);
        step(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1, p, l,
             bit'($urandom_range(0, 1)));
      end else begin
        step(1'b0, $urandom_range(0, 7) != 0, bit'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0);
      end
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_seq_detect.md
PROG_SEQ_DETECT -- requirements
Module: prog_seq_detect

Interface
REQ-001 SHALL have parameter PAT_W, default 16, maximum pattern length in bits (legal 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port EN  input  1  detection enable, active-high.
REQ-006 SHALL have port D_IN  input  1  serial data bit, sampled each enabled rising edge.
REQ-007 SHALL have port CFG_LD  input  1  load strobe for CFG_PAT, CFG_LEN and CFG_OVL.
REQ-008 SHALL have port CFG_PAT  input  PAT_W  pattern; bit LEN-1 is received first, bit 0 last.
REQ-009 SHALL have port CFG_LEN  input  $clog2(PAT_W+1)  active pattern length.
REQ-010 SHALL have port CFG_OVL  input  1  1 = overlapping matches counted, 0 = non-overlapping.
REQ-011 SHALL have port MATCH  output  1  Mealy match flag, high in the same cycle as the final pattern bit.
REQ-012 SHALL have port MATCH_CNT  output  CNT_W  saturating count of matches.
REQ-013 SHALL have port CFG_ERR  output  1  one-cycle registered pulse on a rejected load.

Function
REQ-014 SHALL keep a PAT_W-bit history shift register and a fill counter of bits received since the last restart.
REQ-015 SHALL run FSM states FILL (fill < LEN-1) and RUN (fill >= LEN-1); LEN=1 enters RUN directly.
REQ-016 SHALL assert MATCH combinationally iff EN=1, CFG_LD=0, state=RUN and {hist[LEN-2:0], D_IN} == pat[LEN-1:0].
REQ-017 SHALL, on an enabled edge, shift D_IN into hist[0] and increment fill, saturating at LEN-1.
REQ-018 SHALL, when EN=0, hold history, fill, state and MATCH_CNT, and keep MATCH low.
REQ-019 SHALL, in overlap mode, stay in RUN after a match, so "1010101011" with pattern 10101011 gives one match and "10101011101011" gives one.
REQ-020 SHALL, in non-overlap mode, clear fill and return to FILL on the match edge, so the next match needs LEN fresh bits.
REQ-021 SHALL increment MATCH_CNT on every edge where MATCH=1, saturating at 2^CNT_W-1.
REQ-022 SHALL, on a CFG_LD edge with 1 <= CFG_LEN <= PAT_W, latch the pattern, length and overlap mode, clear history, fill and MATCH_CNT, and enter FILL.
REQ-023 SHALL, on a CFG_LD edge with CFG_LEN=0 or CFG_LEN>PAT_W, ignore the load, keep all state, and pulse CFG_ERR for one cycle.
REQ-024 SHALL give CFG_LD priority over EN; D_IN is not sampled on a load edge.

Reset
REQ-025 SHALL, on RST asserted, immediately set history=0, fill=0, state=FILL, MATCH_CNT=0, CFG_ERR=0, pattern=8'b10101011 zero-extended, LEN=8, OVL=1; MATCH then reads 0.
REQ-026 SHALL, when RST is asserted mid-pattern, discard the partial match with no MATCH pulse, and resume detection from the first enabled edge after release.

Configuration
REQ-027 SHALL compile a load-time pattern check when SEQ_DETECT_CFG_CHECK_EN is defined: a load whose CFG_PAT has any bit set at or above CFG_LEN is also rejected with CFG_ERR.
REQ-028 SHALL, without SEQ_DETECT_CFG_CHECK_EN, silently ignore CFG_PAT bits at or above CFG_LEN and reject only on length.

Structure
REQ-029 SHALL place the FSM state enum, the default pattern constant (8'hAB) and the default length constant (8) in shared package seq_detect_pkg.
REQ-030 SHALL implement the saturating match counter as sub-module seq_match_cnt (CLK, RST, inc, clr, cnt).

Verification
REQ-031 SHALL cover: after reset, D_IN stream 10101011 with EN=1 -> MATCH high only during the 8th bit cycle, MATCH_CNT=1.
REQ-032 SHALL cover: load pattern 101, LEN=3, OVL=1, then stream 10101 -> 2 matches; with OVL=0, same stream -> 1 match.
REQ-033 SHALL cover: EN low for 3 cycles in the middle of 10101011 -> match still on the 8th enabled bit; MATCH=0 while EN=0.
REQ-034 SHALL cover: load CFG_LEN=0 and, separately, CFG_LEN=PAT_W+1 -> CFG_ERR pulse of one cycle, old pattern still matches.
REQ-035 SHALL cover: CNT_W=2 with 5 matches -> MATCH_CNT saturates at 3; RST asserted after 5 bits of a pattern -> no match until 8 new bits.
REQ-036 SHALL cover, with SEQ_DETECT_CFG_CHECK_EN: CFG_PAT=16'h0010 with LEN=4 -> CFG_ERR=1; without the macro -> load accepted.
